// File: rtl/clock_set_ctrl_if.sv
// clock_set_ctrl_if
//   Signal bundle between the clock-setting controller and its neighbours
//   (debounced buttons, 1 Hz timebase, time counter).
//
//   Signals:
//     tick_1hz_in  1 Hz timebase pulse, one cycle wide
//     btn_mode     mode-button pulse, one cycle wide
//     btn_inc      increment-button level, 1 = pressed
//     btn_clr      clear-button pulse, one cycle wide
//     tick_1hz     gated timebase pulse to the time counter
//     inc_hour/inc_min/inc_sec  one-cycle increment pulses
//     clr_time     one-cycle synchronous clear to the time counter
//     mode         current controller state (00 RUN, 01 HOUR, 10 MIN, 11 SEC)
//     edit_sel     one-hot {hour,min,sec} field under edit, 000 in RUN
//
//   Transfer semantics: there is no valid/ready pairing on this bundle.
//   Every pulse signal is a single-cycle strobe that is consumed in the
//   cycle it is high; the receiver can never stall it. btn_inc is a level.
//
//   Modports: slave = controller side, master = driver/environment side.

interface clock_set_ctrl_if;
    logic       tick_1hz_in;
    logic       btn_mode;
    logic       btn_inc;
    logic       btn_clr;
    logic       tick_1hz;
    logic       inc_hour;
    logic       inc_min;
    logic       inc_sec;
    logic       clr_time;
    logic [1:0] mode;
    logic [2:0] edit_sel;

    modport slave (
        input  tick_1hz_in, btn_mode, btn_inc, btn_clr,
        output tick_1hz, inc_hour, inc_min, inc_sec, clr_time, mode, edit_sel
    );

    modport master (
        output tick_1hz_in, btn_mode, btn_inc, btn_clr,
        input  tick_1hz, inc_hour, inc_min, inc_sec, clr_time, mode, edit_sel
    );
endinterface

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl
//   Mode/edit controller for a digital clock. Cycles RUN -> SET_HOUR ->
//   SET_MIN -> SET_SEC -> RUN on the mode button, issues increment pulses
//   (with press-and-hold auto-repeat) to the field selected by the mode,
//   gates the 1 Hz timebase off while editing, and falls back to RUN after
//   TIMEOUT_S seconds without button activity.
//
//   Ports:
//     clk   single clock, rising edge
//     rst   asynchronous active-high reset
//     bus   clock_set_ctrl_if.slave (buttons and timebase in, pulses and
//           status out). All outputs are registered: an input event in
//           cycle N produces its output in cycle N+1. The mode output is
//           the FSM state register itself and doubles as the debug view.

module clock_set_ctrl #(
    parameter int REPEAT_DLY = 25_000_000,
    parameter int REPEAT_PER = 5_000_000,
    parameter int TIMEOUT_S  = 30
) (
    input  logic             clk,
    input  logic             rst,
    clock_set_ctrl_if.slave  bus
);

    localparam int MAX_A = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int MAX_V = (MAX_A > TIMEOUT_S) ? MAX_A : TIMEOUT_S;
    localparam int CNT_W = $clog2(MAX_V + 1);

    localparam logic [CNT_W-1:0] DLY_C     = CNT_W'(REPEAT_DLY);
    localparam logic [CNT_W-1:0] PER_C     = CNT_W'(REPEAT_PER);
    // The timeout fires on the tick that would bring the count to TIMEOUT_S.
    localparam logic [CNT_W-1:0] TO_LAST_C = CNT_W'(TIMEOUT_S - 1);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);
    localparam logic [CNT_W-1:0] SAT_C     = '1;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_SET_HOUR = 2'b01,
        ST_SET_MIN  = 2'b10,
        ST_SET_SEC  = 2'b11
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             rep_on_q, rep_on_d;   // first auto-repeat already issued
    logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
    logic             inc_prev_q;

    logic             tick_q, tick_d;
    logic             inc_hour_q, inc_hour_d;
    logic             inc_min_q, inc_min_d;
    logic             inc_sec_q, inc_sec_d;
    logic             clr_q, clr_d;
    logic [2:0]       edit_q, edit_d;

    logic             in_set;
    logic             inc_edge;
    logic             inc_evt;
    logic             timeout;
    logic             state_chg;

    always_comb begin
        state_d   = state_q;
        rep_cnt_d = rep_cnt_q;
        rep_on_d  = rep_on_q;
        to_cnt_d  = to_cnt_q;
        inc_evt   = 1'b0;

        in_set   = (state_q != ST_RUN);
        inc_edge = bus.btn_inc & ~inc_prev_q;
        timeout  = in_set & bus.tick_1hz_in & (to_cnt_q >= TO_LAST_C);

        // Mode button outranks the timeout return.
        if (bus.btn_mode) begin
            case (state_q)
                ST_RUN:      state_d = ST_SET_HOUR;
                ST_SET_HOUR: state_d = ST_SET_MIN;
                ST_SET_MIN:  state_d = ST_SET_SEC;
                default:     state_d = ST_RUN;
            endcase
        end else if (timeout) begin
            state_d = ST_RUN;
        end
        state_chg = (state_d != state_q);

        // Increment / auto-repeat. A nonzero rep_cnt_q means a press was
        // accepted in this state, so holding the button across a mode change
        // or reset never starts repeating without a fresh press.
        if (!in_set || !bus.btn_inc || state_chg) begin
            rep_cnt_d = '0;
            rep_on_d  = 1'b0;
        end else if (inc_edge) begin
            inc_evt   = 1'b1;
            rep_cnt_d = ONE_C;
            rep_on_d  = 1'b0;
        end else if (rep_cnt_q != '0) begin
            if (rep_cnt_q >= (rep_on_q ? PER_C : DLY_C)) begin
                inc_evt   = 1'b1;
                rep_cnt_d = ONE_C;
                rep_on_d  = 1'b1;
            end else if (rep_cnt_q != SAT_C) begin
                rep_cnt_d = rep_cnt_q + ONE_C;
            end
        end

        // Inactivity timer: seconds spent editing without any button action.
        if (!in_set || state_chg || bus.btn_clr || inc_evt) begin
            to_cnt_d = '0;
        end else if (bus.tick_1hz_in && to_cnt_q != SAT_C) begin
            to_cnt_d = to_cnt_q + ONE_C;
        end

        // Timebase passes only when RUN both now and next, so the exit cycle
        // out of SET_SEC and the entry cycle into SET_HOUR stay quiet.
        tick_d     = bus.tick_1hz_in & (state_q == ST_RUN) & (state_d == ST_RUN);
        inc_hour_d = inc_evt & (state_q == ST_SET_HOUR);
        inc_min_d  = inc_evt & (state_q == ST_SET_MIN);
        inc_sec_d  = inc_evt & (state_q == ST_SET_SEC);
        clr_d      = bus.btn_clr;

        case (state_d)
            ST_SET_HOUR: edit_d = 3'b100;
            ST_SET_MIN:  edit_d = 3'b010;
            ST_SET_SEC:  edit_d = 3'b001;
            default:     edit_d = 3'b000;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_RUN;
            rep_cnt_q  <= '0;
            rep_on_q   <= 1'b0;
            to_cnt_q   <= '0;
            inc_prev_q <= 1'b0;
            tick_q     <= 1'b0;
            inc_hour_q <= 1'b0;
            inc_min_q  <= 1'b0;
            inc_sec_q  <= 1'b0;
            clr_q      <= 1'b0;
            edit_q     <= 3'b000;
        end else begin
            state_q    <= state_d;
            rep_cnt_q  <= rep_cnt_d;
            rep_on_q   <= rep_on_d;
            to_cnt_q   <= to_cnt_d;
            inc_prev_q <= bus.btn_inc;
            tick_q     <= tick_d;
            inc_hour_q <= inc_hour_d;
            inc_min_q  <= inc_min_d;
            inc_sec_q  <= inc_sec_d;
            clr_q      <= clr_d;
            edit_q     <= edit_d;
        end
    end

    assign bus.tick_1hz = tick_q;
    assign bus.inc_hour = inc_hour_q;
    assign bus.inc_min  = inc_min_q;
    assign bus.inc_sec  = inc_sec_q;
    assign bus.clr_time = clr_q;
    assign bus.mode     = state_q;
    assign bus.edit_sel = edit_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl
//   Directed bench for clock_set_ctrl with REPEAT_DLY=8, REPEAT_PER=3,
//   TIMEOUT_S=4. Inputs change 1 time unit after a rising edge; outputs are
//   read 1 time unit after the following edge, so each drive() call is one
//   cycle and the values read after it are the registered response.

module tb_clock_set_ctrl;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  clock_set_ctrl_if bus ();

  clock_set_ctrl #(
    .REPEAT_DLY(8),
    .REPEAT_PER(3),
    .TIMEOUT_S (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic drive(input logic m, input logic i, input logic c, input logic t);
    bus.btn_mode    = m;
    bus.btn_inc     = i;
    bus.btn_clr     = c;
    bus.tick_1hz_in = t;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.btn_mode = 1'b0; bus.btn_inc = 1'b0; bus.btn_clr = 1'b0; bus.tick_1hz_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.btn_mode = 1'b0; bus.btn_inc = 1'b0; bus.btn_clr = 1'b0; bus.tick_1hz_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (bus.mode !== 2'b00) begin
      tests_failed++; $display("FAIL reset_mode act=%b exp=00", bus.mode);
    end
    tests_run++;
    if (bus.edit_sel !== 3'b000) begin
      tests_failed++; $display("FAIL reset_edit act=%b exp=000", bus.edit_sel);
    end
    tests_run++;
    if ({bus.tick_1hz, bus.inc_hour, bus.inc_min, bus.inc_sec, bus.clr_time} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_pulses act=%b exp=00000",
               {bus.tick_1hz, bus.inc_hour, bus.inc_min, bus.inc_sec, bus.clr_time});
    end
    bus.tick_1hz_in = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_mode_cycle();
    logic [1:0] exp_mode [3];
    logic [2:0] exp_edit [3];
    exp_mode[0] = 2'b01; exp_mode[1] = 2'b10; exp_mode[2] = 2'b11;
    exp_edit[0] = 3'b100; exp_edit[1] = 3'b010; exp_edit[2] = 3'b001;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b1);
      tests_run++;
      if (bus.mode !== exp_mode[k] || bus.edit_sel !== exp_edit[k]) begin
        tests_failed++;
        $display("FAIL mode_step%0d act=%b/%b exp=%b/%b", k, bus.mode, bus.edit_sel,
                 exp_mode[k], exp_edit[k]);
      end
      tests_run++;
      if (bus.tick_1hz !== 1'b0) begin
        tests_failed++; $display("FAIL mode_tick_gated%0d act=%b exp=0", k, bus.tick_1hz);
      end
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      tests_run++;
      if (bus.tick_1hz !== 1'b0) begin
        tests_failed++; $display("FAIL mode_tick_held%0d act=%b exp=0", k, bus.tick_1hz);
      end
    end
    // exit SET_SEC -> RUN with a tick in the exit cycle: not forwarded
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    tests_run++;
    if (bus.mode !== 2'b00 || bus.edit_sel !== 3'b000 || bus.tick_1hz !== 1'b0) begin
      tests_failed++;
      $display("FAIL mode_exit act=%b/%b/%b exp=00/000/0", bus.mode, bus.edit_sel, bus.tick_1hz);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    tests_run++;
    if (bus.tick_1hz !== 1'b1) begin
      tests_failed++; $display("FAIL mode_run_tick act=%b exp=1", bus.tick_1hz);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (bus.tick_1hz !== 1'b0) begin
      tests_failed++; $display("FAIL mode_run_tick_low act=%b exp=0", bus.tick_1hz);
    end
  endtask

  task automatic test_repeat();
    logic [2:0] exp_inc;
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    // btn_inc high for cycles 10..29; inc_min expected in cycles 11,19,22,25,28
    for (int c = 0; c < 40; c++) begin
      drive(1'b0, (c >= 10 && c < 30), 1'b0, 1'b0);
      exp_inc = (c == 10 || c == 18 || c == 21 || c == 24 || c == 27) ? 3'b010 : 3'b000;
      tests_run++;
      if ({bus.inc_hour, bus.inc_min, bus.inc_sec} !== exp_inc) begin
        tests_failed++;
        $display("FAIL repeat_cycle%0d act=%b exp=%b", c + 1,
                 {bus.inc_hour, bus.inc_min, bus.inc_sec}, exp_inc);
      end
    end
  endtask

  task automatic test_mode_inc_collision();
    int pulses;
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    tests_run++;
    if (bus.mode !== 2'b10 || bus.inc_hour !== 1'b0 || bus.inc_min !== 1'b0) begin
      tests_failed++;
      $display("FAIL collide_step act=%b/%b/%b exp=10/0/0", bus.mode, bus.inc_hour, bus.inc_min);
    end
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      pulses += int'(bus.inc_hour) + int'(bus.inc_min) + int'(bus.inc_sec);
    end
    tests_run++;
    if (pulses != 0) begin
      tests_failed++; $display("FAIL collide_hold_pulses act=%0d exp=0", pulses);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    repeat (3) drive(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
    end
    tests_run++;
    if (bus.mode !== 2'b11) begin
      tests_failed++; $display("FAIL timeout_before act=%b exp=11", bus.mode);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    tests_run++;
    if (bus.mode !== 2'b00 || bus.tick_1hz !== 1'b0) begin
      tests_failed++; $display("FAIL timeout_exit act=%b/%b exp=00/0", bus.mode, bus.tick_1hz);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    tests_run++;
    if (bus.tick_1hz !== 1'b1) begin
      tests_failed++; $display("FAIL timeout_tick_resumes act=%b exp=1", bus.tick_1hz);
    end

    // an inc pulse restarts the inactivity count
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    tests_run++;
    if (bus.inc_hour !== 1'b1) begin
      tests_failed++; $display("FAIL timeout_inc_pulse act=%b exp=1", bus.inc_hour);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
    end
    tests_run++;
    if (bus.mode !== 2'b01) begin
      tests_failed++; $display("FAIL timeout_restarted act=%b exp=01", bus.mode);
    end
    // mode button in the timeout cycle wins: SET_HOUR -> SET_MIN
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    tests_run++;
    if (bus.mode !== 2'b10) begin
      tests_failed++; $display("FAIL timeout_mode_priority act=%b exp=10", bus.mode);
    end
  endtask

  task automatic test_clear();
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    tests_run++;
    if (bus.clr_time !== 1'b1 || bus.tick_1hz !== 1'b1 ||
        {bus.inc_hour, bus.inc_min, bus.inc_sec} !== 3'b000) begin
      tests_failed++;
      $display("FAIL clr_run act=%b/%b/%b exp=1/1/000", bus.clr_time, bus.tick_1hz,
               {bus.inc_hour, bus.inc_min, bus.inc_sec});
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    tests_run++;
    if (bus.clr_time !== 1'b0 || bus.tick_1hz !== 1'b0) begin
      tests_failed++; $display("FAIL clr_run_after act=%b/%b exp=0/0", bus.clr_time, bus.tick_1hz);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    tests_run++;
    if (bus.tick_1hz !== 1'b1 || bus.clr_time !== 1'b0 || bus.mode !== 2'b00) begin
      tests_failed++;
      $display("FAIL clr_run_tick act=%b/%b/%b exp=1/0/00", bus.tick_1hz, bus.clr_time, bus.mode);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    tests_run++;
    if (bus.clr_time !== 1'b1 || bus.mode !== 2'b10) begin
      tests_failed++; $display("FAIL clr_with_mode act=%b/%b exp=1/10", bus.clr_time, bus.mode);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    tests_run++;
    if (bus.clr_time !== 1'b1 || bus.mode !== 2'b10) begin
      tests_failed++; $display("FAIL clr_in_set act=%b/%b exp=1/10", bus.clr_time, bus.mode);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (bus.clr_time !== 1'b0) begin
      tests_failed++; $display("FAIL clr_one_cycle act=%b exp=0", bus.clr_time);
    end
  endtask

  task automatic test_reset_mid_repeat();
    int pulses;
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    tests_run++;
    if (bus.inc_min !== 1'b1) begin
      tests_failed++; $display("FAIL rstrep_first act=%b exp=1", bus.inc_min);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    // asynchronous reset mid-cycle, 2 cycles into the hold
    rst = 1'b1;
    #1;
    tests_run++;
    if (bus.mode !== 2'b00 || bus.edit_sel !== 3'b000 || bus.inc_min !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstrep_async act=%b/%b/%b exp=00/000/0", bus.mode, bus.edit_sel, bus.inc_min);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    pulses = 0;
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    tests_run++;
    if (bus.mode !== 2'b10) begin
      tests_failed++; $display("FAIL rstrep_reenter act=%b exp=10", bus.mode);
    end
    for (int c = 0; c < 12; c++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      pulses += int'(bus.inc_min);
    end
    tests_run++;
    if (pulses != 0) begin
      tests_failed++; $display("FAIL rstrep_no_pulse act=%0d exp=0", pulses);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    tests_run++;
    if (bus.inc_min !== 1'b1) begin
      tests_failed++; $display("FAIL rstrep_new_press act=%b exp=1", bus.inc_min);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst = 1'b1;
    bus.btn_mode = 1'b0; bus.btn_inc = 1'b0; bus.btn_clr = 1'b0; bus.tick_1hz_in = 1'b0;
    test_reset();
    test_mode_cycle();
    test_repeat();
    test_mode_inc_collision();
    test_timeout();
    test_clear();
    test_reset_mid_repeat();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
